// File: rtl/pipe_pkg.sv
// Shared pipeline package for the RV32IM core.
// Holds the per-stage control-field layouts and their bubble values.
// A bubble is a control word that performs no memory access and no register write.
// Stage registers are built like this:
//   pipe_stage_reg #(.CTRL_W($bits(ex_mem_ctrl_t)), .CTRL_RST(EX_MEM_CTRL_BUBBLE))
// The package also holds the handshake helper used by pipe_stage_reg.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 16;

  // EX/MEM control word (16 bits).
  // load_type 3'b111 and store_type 2'b11 are the "no access" codes.
  typedef struct packed {
    logic       reg_we;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic [4:0] rd;
    logic [4:0] alu_op;
  } ex_mem_ctrl_t;

  localparam ex_mem_ctrl_t EX_MEM_CTRL_BUBBLE = '{
    reg_we:     1'b0,
    load_type:  3'b111,
    store_type: 2'b11,
    rd:         5'd0,
    alu_op:     5'd0
  };

  // MEM/WB control word (8 bits).
  typedef struct packed {
    logic       reg_we;
    logic [4:0] rd;
    logic [1:0] wb_sel;
  } mem_wb_ctrl_t;

  localparam mem_wb_ctrl_t MEM_WB_CTRL_BUBBLE = '{
    reg_we: 1'b0,
    rd:     5'd0,
    wb_sel: 2'b00
  };

  // A transfer happens on an edge where both valid and ready are high.
  function automatic logic xfer(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage register (upstream side and downstream side).
//
// Handshake semantics:
// - An entry moves on a rising edge where valid & ready.
// - A producer that raises valid keeps valid, data and ctrl stable until the entry is taken.
// - ready may depend on the consumer's own state only. It never depends on the valid that it answers.
//
// Modports:
//   slave  - the stage register itself: it receives in_* and out_ready, and drives in_ready and out_*.
//   master - the surrounding pipeline/environment: it drives in_* and out_ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// One valid+payload register slot.
// The stage register uses this slot for its main entry and for its skid entry.
//
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset
//   clear             - empty the slot: ctrl returns to CTRL_RST and data holds its value
//   load              - capture d_data/d_ctrl and mark the slot valid (clear has priority)
//   d_data, d_ctrl    - payload to load
//   valid, q_*        - slot contents; q_ctrl equals CTRL_RST whenever valid is 0
module pipe_skid_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      q_data <= '0;
      q_ctrl <= CTRL_RST;
    end else if (clear) begin
      valid  <= 1'b0;
      q_ctrl <= CTRL_RST;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// The payload has a data field and a control field.
// The control field reads CTRL_RST whenever the stage presents no valid entry.
// This means a stalled or empty stage never issues stale memory or register writes.
//
// Parameters: DATA_W, CTRL_W, CTRL_RST (bubble control word), SKID, CNT_W.
//   SKID = 1: two-entry skid buffer. in_ready is a register output.
//   SKID = 0: single register. in_ready is combinational (!out_valid | out_ready).
//
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   flush       - squashes every held entry. An input offered in the same cycle is dropped.
//   bus         - pipe_stage_reg_if.slave (in_* upstream handshake, out_* downstream handshake)
//   perf_stall_cnt, perf_bubble_cnt - saturating counters. Present only when the macro
//                 PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int unsigned SKID = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]   perf_stall_cnt,
  output logic [CNT_W-1:0]   perf_bubble_cnt,
`endif
  pipe_stage_reg_if.slave    bus
);

  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: DATA_W, CTRL_W and CNT_W must be at least 1");
  end

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              take;
  logic              emit;

  // The upstream handshake can complete during a flush. The entry is still discarded.
  assign take = xfer(bus.in_valid, bus.in_ready) & ~flush;
  assign emit = xfer(main_valid, bus.out_ready);

  if (SKID != 0) begin : g_skid
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              skid_load;
    logic              skid_clear;
    logic              main_free;

    // The main register can take a new entry when it is empty or draining this cycle.
    assign main_free = ~main_valid | bus.out_ready;
    // Only the skid occupancy gates in_ready. No path exists from out_ready.
    assign bus.in_ready = ~skid_valid;

    always_comb begin
      main_load   = 1'b0;
      main_clear  = 1'b0;
      main_d_data = bus.in_data;
      main_d_ctrl = bus.in_ctrl;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      if (flush) begin
        main_clear = 1'b0 | 1'b1;
        skid_clear = 1'b1;
      end else if (skid_valid) begin
        // in_ready is low in this cycle, so nothing is accepted. A draining main register refills from skid.
        main_d_data = skid_data;
        main_d_ctrl = skid_ctrl;
        main_load   = emit;
        skid_clear  = emit;
      end else begin
        main_load  = take & main_free;
        skid_load  = take & ~main_free;
        main_clear = emit & ~(take & main_free);
      end
    end

    pipe_skid_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
    ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (skid_clear),
      .load   (skid_load),
      .d_data (bus.in_data),
      .d_ctrl (bus.in_ctrl),
      .valid  (skid_valid),
      .q_data (skid_data),
      .q_ctrl (skid_ctrl)
    );
  end else begin : g_noskid
    assign bus.in_ready = ~main_valid | bus.out_ready;

    always_comb begin
      main_d_data = bus.in_data;
      main_d_ctrl = bus.in_ctrl;
      main_load   = take;
      main_clear  = flush | (emit & ~take);
    end
  end

  pipe_skid_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (main_clear),
    .load   (main_load),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );

  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  // Flush does not clear these counters. Only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (main_valid && !bus.out_ready && !(&perf_stall_cnt)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (!main_valid && !(&perf_bubble_cnt)) begin
        perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg.
// It drives two instances from the same stimulus:
//   u_dut1 - SKID=1, used by the hand-written multi-cycle sequences
//   u_dut0 - SKID=0, used by the vector table
// Both instances use CTRL_RST=16'h00F7. The perf counters are checked only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] BUB = 16'h00F7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();

`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall1, bubble1, stall0, bubble0;
`endif

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(BUB), .SKID(1), .CNT_W(NW)
  ) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
`ifdef PIPE_STAGE_PERF_EN
    .perf_stall_cnt  (stall1),
    .perf_bubble_cnt (bubble1),
`endif
    .bus             (bus1)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(BUB), .SKID(0), .CNT_W(NW)
  ) u_dut0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
`ifdef PIPE_STAGE_PERF_EN
    .perf_stall_cnt  (stall0),
    .perf_bubble_cnt (bubble0),
`endif
    .bus             (bus0)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic          e_rdy;  // in_ready before the edge
    logic          e_v;    // out_valid after the edge
    logic [DW-1:0] e_d;
    logic [CW-1:0] e_c;
    logic          chk_d;  // out_data is defined for this row
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    bus1.in_valid  = v;    bus0.in_valid  = v;
    bus1.in_data   = d;    bus0.in_data   = d;
    bus1.in_ctrl   = c;    bus0.in_ctrl   = c;
    bus1.out_ready = ordy; bus0.out_ready = ordy;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'hDEAD_BEEF, 16'hFFFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e;

    tbl[0]  = '{1'b1, 32'h11, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 16'h0101, 1'b1};
    tbl[1]  = '{1'b1, 32'h22, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 16'h0101, 1'b1};
    tbl[2]  = '{1'b1, 32'h22, 16'h0202, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 16'h0202, 1'b1};
    tbl[3]  = '{1'b0, 32'h33, 16'h0303, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, BUB,      1'b0};
    tbl[4]  = '{1'b1, 32'h44, 16'h0404, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 16'h0404, 1'b1};
    tbl[5]  = '{1'b1, 32'h55, 16'h0505, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, BUB,      1'b1};
    tbl[6]  = '{1'b0, 32'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, BUB,      1'b0};
    tbl[7]  = '{1'b1, 32'h66, 16'h0606, 1'b1, 1'b0, 1'b1, 1'b1, 32'h66, 16'h0606, 1'b1};
    tbl[8]  = '{1'b1, 32'h77, 16'h0707, 1'b1, 1'b0, 1'b1, 1'b1, 32'h77, 16'h0707, 1'b1};
    tbl[9]  = '{1'b0, 32'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 16'h0707, 1'b1};
    tbl[10] = '{1'b0, 32'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, BUB,      1'b0};

    // Reset with in_valid high
    do_reset();
    check("rst out_valid s1", bus1.out_valid, 1'b0);
    check("rst out_ctrl s1", bus1.out_ctrl, BUB);
    check("rst out_data s1", bus1.out_data, 32'h0);
    check("rst out_valid s0", bus0.out_valid, 1'b0);
    check("rst out_ctrl s0", bus0.out_ctrl, BUB);
    check("rst out_data s0", bus0.out_data, 32'h0);
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    #1;
    check("rst in_ready s1", bus1.in_ready, 1'b1);
    check("rst in_ready s0", bus0.in_ready, 1'b1);

    // SKID=0 vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl);
      #1;
      check($sformatf("tbl[%0d] in_ready", i), bus0.in_ready, tbl[i].e_rdy);
      tick();
      check($sformatf("tbl[%0d] out_valid", i), bus0.out_valid, tbl[i].e_v);
      check($sformatf("tbl[%0d] out_ctrl", i), bus0.out_ctrl, tbl[i].e_c);
      if (tbl[i].chk_d) check($sformatf("tbl[%0d] out_data", i), bus0.out_data, tbl[i].e_d);
    end

    // SKID=1 streaming: 0x10..0x1F, one per cycle
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 32'h10 + DW'(k), 16'h0100 + CW'(k), 1'b1, 1'b0);
      #1;
      check("stream in_ready", bus1.in_ready, 1'b1);
      exp_q.push_back(32'h10 + DW'(k));
      tick();
      e = exp_q.pop_front();
      check("stream out_valid", bus1.out_valid, 1'b1);
      check("stream out_data", bus1.out_data, e);
    end
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("stream drained", bus1.out_valid, 1'b0);

    // Backpressure: 0xA in main, 0xB in skid, then stall
    drive(1'b1, 32'hA, 16'h000A, 1'b0, 1'b0);
    #1;
    check("bp in_ready A", bus1.in_ready, 1'b1);
    tick();
    check("bp out_data A", bus1.out_data, 32'hA);
    drive(1'b1, 32'hB, 16'h000B, 1'b0, 1'b0);
    #1;
    check("bp in_ready B", bus1.in_ready, 1'b1);
    tick();
    check("bp in_ready full", bus1.in_ready, 1'b0);
    drive(1'b1, 32'hDD, 16'h00DD, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp hold valid", bus1.out_valid, 1'b1);
      check("bp hold data", bus1.out_data, 32'hA);
      check("bp hold ctrl", bus1.out_ctrl, 16'h000A);
      check("bp hold in_ready", bus1.in_ready, 1'b0);
    end
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("bp drain B valid", bus1.out_valid, 1'b1);
    check("bp drain B data", bus1.out_data, 32'hB);
    check("bp drain B ctrl", bus1.out_ctrl, 16'h000B);
    check("bp drain in_ready", bus1.in_ready, 1'b1);
    tick();
    check("bp empty valid", bus1.out_valid, 1'b0);
    check("bp empty ctrl", bus1.out_ctrl, BUB);

    // Flush with two entries held; 0xC offered in the flush cycle
    drive(1'b1, 32'h1, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 16'h0002, 1'b0, 1'b0);
    tick();
    check("fl full in_ready", bus1.in_ready, 1'b0);
    drive(1'b1, 32'hC, 16'h0C0C, 1'b0, 1'b1);
    tick();
    check("fl out_valid", bus1.out_valid, 1'b0);
    check("fl out_ctrl", bus1.out_ctrl, BUB);
    check("fl out_data held", bus1.out_data, 32'h1);
    check("fl in_ready", bus1.in_ready, 1'b1);
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl nothing emerges", bus1.out_valid, 1'b0);
    end
    // Flush on an empty stage while the handshake completes
    drive(1'b1, 32'hE, 16'h0E0E, 1'b1, 1'b1);
    #1;
    check("fl2 in_ready", bus1.in_ready, 1'b1);
    tick();
    check("fl2 input dropped", bus1.out_valid, 1'b0);
    check("fl2 out_ctrl", bus1.out_ctrl, BUB);

    // Bubble control after emit with no new input
    drive(1'b1, 32'h55, 16'h1234, 1'b0, 1'b0);
    tick();
    check("bub held ctrl", bus1.out_ctrl, 16'h1234);
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("bub out_valid", bus1.out_valid, 1'b0);
    check("bub out_ctrl", bus1.out_ctrl, BUB);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("perf bubble 3 s1", bubble1, 4'd3);
    check("perf stall 0 s1", stall1, 4'd0);
    drive(1'b1, 32'h77, 16'h0077, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    check("perf stall sat s1", stall1, 4'hF);
    check("perf bubble 4 s1", bubble1, 4'd4);
    check("perf stall sat s0", stall0, 4'hF);
    check("perf bubble 4 s0", bubble0, 4'd4);
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    check("perf flush valid", bus1.out_valid, 1'b0);
    check("perf stall kept s1", stall1, 4'hF);
    check("perf bubble kept s1", bubble1, 4'd4);
    check("perf stall kept s0", stall0, 4'hF);
    tick();
    check("perf bubble 5 s1", bubble1, 4'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register for the RV32IM core. It replaces hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake stage.
- Payload is split into a data field and a control field. Control is forced to a safe bubble value whenever the stage is empty or flushed.
- An optional two-entry skid buffer cuts the combinational ready path between stages.

Parameters:
- DATA_W, 32: width of datapath payload (results, PC, immediates, operands).
- CTRL_W, 16: width of control payload (write enables, load/store types, rd, opcode).
- CTRL_RST, 0: bubble/reset value of the control field (CTRL_W bits). It must encode "no memory access, no register write".
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control payload; equals CTRL_RST whenever out_valid=0.

Behaviour:
- Transfers: accept when in_valid & in_ready; emit when out_valid & out_ready.
- Reset (rst_n=0 at edge):
  - out_valid=0, out_data=0, out_ctrl=CTRL_RST, skid entry empty with skid data/ctrl zeroed.
  - in_ready=1 in the first cycle after reset (both modes).
- Priority: reset > flush > normal operation.
- Flush:
  - Clears out_valid and skid_valid; out_ctrl<=CTRL_RST; out_data holds its previous value.
  - An input presented in the flush cycle is discarded even if in_valid & in_ready.
  - in_ready=1 the following cycle.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, main register loads in_data/in_ctrl and out_valid=1.
  - On emit with no accept, out_valid=0 and out_ctrl=CTRL_RST.
  - Latency 1 cycle; full throughput.
- SKID=1:
  - in_ready = !skid_valid (pure register output, no path from out_ready).
  - If main is empty or emitting: accept loads main; a valid skid entry loads main first, and in that cycle in_ready was 0 so no accept occurs.
  - If main is full and not emitting: accept loads skid, skid_valid=1.
  - Emit with skid valid: main<=skid, skid_valid<=0 next cycle.
  - Latency 1 cycle; full throughput; capacity 2 entries.
- Ordering: entries leave strictly in acceptance order; no duplication or loss except on flush.
- Stability: while out_valid & !out_ready, out_data and out_ctrl hold stable.
- Empty stage: out_ctrl never leaks stale control. Any cycle with out_valid=0 presents CTRL_RST, replacing ad-hoc clearing of memory read/write on stall.
- Simultaneous flush and out_ready: the flush wins; the emitted entry in that cycle is still counted as transferred downstream.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_stall_cnt[CNT_W] and perf_bubble_cnt[CNT_W].
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_bubble_cnt increments each cycle with !out_valid.
  - Both saturate at all-ones, reset to 0 on rst_n=0, and are not cleared by flush.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds the control-field struct typedefs per stage (ex_mem_ctrl_t etc.) and their bubble constants (EX_MEM_CTRL_BUBBLE, with load_type 3'b111 and store_type 2'b11). Instances pass $bits() and these constants into CTRL_W and CTRL_RST.
- One natural sub-module, pipe_skid_slot: a single valid+payload register with load/clear, instantiated twice for main and skid.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=CTRL_RST, out_data=0; in_ready=1 the first cycle after release.
- Streaming: SKID=1, out_ready=1, in_valid=1 with data 0x10..0x1F over 16 cycles -> outputs 0x10..0x1F in order, one per cycle, starting 1 cycle after first accept.
- Backpressure: accept 0xA then 0xB, then out_ready=0 -> in_ready drops to 0 after 0xB enters skid; out_data=0xA stays stable. Raising out_ready yields 0xA then 0xB with no loss.
- Flush: two entries held, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=CTRL_RST, 0xC never appears at the output.
- Bubble control: CTRL_RST=16'h00F7, accept ctrl 16'h1234, then emit with no new input -> out_ctrl reads 16'h00F7 while out_valid=0.
- Perf (macro defined, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> perf_stall_cnt saturates at 4'hF; flush leaves it unchanged.
